// File: rtl/pw_trigger_seq.sv
// pw_trigger_seq: multi-pulse trigger sequencer.
// A qualified I_match starts a sequence of up to pNUM_PULSES pulses. Each pulse
// has its own delay and width. Every output is a flop decoded from the FSM
// state held one cycle earlier, so the outputs form a clean one-cycle pipeline
// behind the state machine.
module pw_trigger_seq #(
    parameter int pNUM_PULSES          = 4,
    parameter int pIDX_WIDTH           = 3,
    parameter int pTRIGGER_DELAY_WIDTH = 20,
    parameter int pTRIGGER_WIDTH_WIDTH = 17
) (
    input  logic                                          trigger_clk,
    input  logic                                          reset_i,
    input  logic                                          I_arm,
    input  logic                                          I_match,
    input  logic [pIDX_WIDTH-1:0]                         I_num_pulses,
    input  logic [pNUM_PULSES*pTRIGGER_DELAY_WIDTH-1:0]   I_delays,
    input  logic [pNUM_PULSES*pTRIGGER_WIDTH_WIDTH-1:0]   I_widths,
    output logic                                          O_trigger,
    output logic                                          O_busy,
    output logic [pIDX_WIDTH-1:0]                         O_pulse_index,
    output logic                                          O_done,
    output logic                                          O_capture_enable
);

    localparam int pCNT_WIDTH = (pTRIGGER_DELAY_WIDTH > pTRIGGER_WIDTH_WIDTH) ?
                                pTRIGGER_DELAY_WIDTH : pTRIGGER_WIDTH_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t                                        r_state;
    state_t                                        w_nextState;
    logic [pCNT_WIDTH-1:0]                         r_count;
    logic [pCNT_WIDTH-1:0]                         w_nextCount;
    logic [pIDX_WIDTH-1:0]                         r_idx;
    logic [pIDX_WIDTH-1:0]                         w_nextIdx;
    logic [pIDX_WIDTH-1:0]                         w_succIdx;
    logic [pIDX_WIDTH-1:0]                         r_num;
    logic [pIDX_WIDTH-1:0]                         w_numClamped;
    logic [pNUM_PULSES*pTRIGGER_DELAY_WIDTH-1:0]   r_delays;
    logic [pNUM_PULSES*pTRIGGER_WIDTH_WIDTH-1:0]   r_widths;
    logic [pTRIGGER_DELAY_WIDTH-1:0]               w_firstDelay;
    logic [pTRIGGER_WIDTH_WIDTH-1:0]               w_firstWidth;
    logic [pTRIGGER_WIDTH_WIDTH-1:0]               w_curWidth;
    logic [pTRIGGER_DELAY_WIDTH-1:0]               w_succDelay;
    logic                                          w_start;
    logic                                          w_finish;
    logic                                          w_lastPulse;
    logic                                          r_finish;
    logic                                          r_armQ;

    // A zero field is treated as one cycle; the counter runs from N-1 down to 0.
    function automatic logic [pCNT_WIDTH-1:0] loadValue(input logic [pCNT_WIDTH-1:0] v);
        return (v == '0) ? '0 : (v - pCNT_WIDTH'(1));
    endfunction

    assign w_numClamped = (I_num_pulses > pIDX_WIDTH'(pNUM_PULSES)) ?
                          pIDX_WIDTH'(pNUM_PULSES) : I_num_pulses;
    assign w_firstDelay = I_delays[pTRIGGER_DELAY_WIDTH-1:0];
    assign w_firstWidth = I_widths[pTRIGGER_WIDTH_WIDTH-1:0];
    assign w_lastPulse  = (r_idx == (r_num - pIDX_WIDTH'(1)));
    assign w_succIdx    = (int'(r_idx) >= pNUM_PULSES - 1) ? '0 : (r_idx + pIDX_WIDTH'(1));
    assign w_curWidth   = r_widths[int'(r_idx)*pTRIGGER_WIDTH_WIDTH +: pTRIGGER_WIDTH_WIDTH];
    assign w_succDelay  = r_delays[int'(w_succIdx)*pTRIGGER_DELAY_WIDTH +: pTRIGGER_DELAY_WIDTH];

    // Next-state logic: start qualification, delay/width countdown, abort on I_arm low.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextIdx   = r_idx;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (I_arm && I_match && (I_num_pulses != '0)) begin
                    w_start   = 1'b1;
                    w_nextIdx = '0;
                    if (w_firstDelay == '0) begin
                        w_nextState = PULSE;
                        w_nextCount = loadValue(pCNT_WIDTH'(w_firstWidth));
                    end else begin
                        w_nextState = DELAY;
                        w_nextCount = pCNT_WIDTH'(w_firstDelay) - pCNT_WIDTH'(1);
                    end
                end
            end
            DELAY: begin
                if (!I_arm) begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                    w_nextIdx   = '0;
                end else if (r_count == '0) begin
                    w_nextState = PULSE;
                    w_nextCount = loadValue(pCNT_WIDTH'(w_curWidth));
                end else begin
                    w_nextCount = r_count - pCNT_WIDTH'(1);
                end
            end
            PULSE: begin
                if (!I_arm) begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                    w_nextIdx   = '0;
                end else if (r_count == '0) begin
                    if (w_lastPulse) begin
                        w_nextState = IDLE;
                        w_nextCount = '0;
                        w_nextIdx   = '0;
                        w_finish    = 1'b1;
                    end else begin
                        w_nextState = DELAY;
                        w_nextIdx   = w_succIdx;
                        w_nextCount = loadValue(pCNT_WIDTH'(w_succDelay));
                    end
                end else begin
                    w_nextCount = r_count - pCNT_WIDTH'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = '0;
                w_nextIdx   = '0;
            end
        endcase
    end

    // FSM state, countdown and pulse index registers.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_idx    <= '0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_idx    <= w_nextIdx;
            r_finish <= w_finish;
        end
    end

    // Configuration snapshot taken at the start edge; ignored until the next start.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            r_num    <= '0;
            r_delays <= '0;
            r_widths <= '0;
        end else if (w_start) begin
            r_num    <= w_numClamped;
            r_delays <= I_delays;
            r_widths <= I_widths;
        end
    end

    // Registered outputs decoded from the previous cycle's state; capture enable is sticky.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            O_trigger        <= 1'b0;
            O_busy           <= 1'b0;
            O_pulse_index    <= '0;
            O_done           <= 1'b0;
            O_capture_enable <= 1'b0;
            r_armQ           <= 1'b0;
        end else begin
            O_trigger     <= (r_state == PULSE);
            O_busy        <= (r_state != IDLE);
            O_pulse_index <= r_idx;
            O_done        <= r_finish;
            r_armQ        <= I_arm;
            if (!r_armQ) begin
                O_capture_enable <= 1'b0;
            end else if ((r_state == PULSE) && (r_idx == '0)) begin
                O_capture_enable <= 1'b1;
            end
        end
    end

endmodule
